apb_axi_sequencer: RTL and testbench
====================================

// Module: apb_axi_sequencer
// PURPOSE
//  Converts AXI4-Lite read/write requests into APB transfers and drives the single APB master datapath.
//  Round-robin arbitration between the read channel (AR) and the write channels (AW+W).
//  Runs the SETUP->ACCESS phase sequence, a PREADY timeout and response generation.
//  Sits between the AXI-facing port and the APB slave mux; the mux decodes PADDR into per-slave PSELs.
// PARAMETERS
//  ADDR_WIDTH      32  AXI/APB address width
//  DATA_WIDTH      32  AXI/APB data width (STRB width = DATA_WIDTH/8)
//  TIMEOUT_CYCLES  16  ACCESS cycles without PREADY before forced SLVERR; 0 = timeout disabled
// PORTS
//  PCLK     in   1         clock, all logic rising-edge
//  PRESET   in   1         reset, synchronous, active-high
//  AWADDR   in   AW        write address;  AWVALID in 1;  AWREADY out 1
//  WDATA    in   DW        write data;  WSTRB in DW/8;  WVALID in 1;  WREADY out 1
//  BRESP    out  2         write response;  BVALID out 1;  BREADY in 1
//  ARADDR   in   AW        read address;  ARVALID in 1;  ARREADY out 1
//  RDATA    out  DW        read data;  RRESP out 2;  RVALID out 1;  RREADY in 1
//  PSEL     out  1         APB select (to mux);  PENABLE out 1;  PWRITE out 1
//  PADDR    out  AW        APB address;  PWDATA out DW;  PSTRB out DW/8 (all 0 on reads)
//  PRDATA   in   DW        APB read data;  PREADY in 1;  PSLVERR in 1
//  error    out  1         1-cycle pulse when any response completes with SLVERR
// BEHAVIOUR
//  Reset: state=IDLE; all *READY/*VALID, PSEL, PENABLE, PWRITE, error = 0; PADDR/PWDATA/PSTRB/RDATA = 0;
//   BRESP/RRESP = 2'b00; rr_last = READ, so a write wins the first tie.
//  FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//  IDLE
//   - Write is eligible only when AWVALID & WVALID are both high; read is eligible when ARVALID is high.
//   - One eligible request: it is granted. Both eligible: grant the type opposite to rr_last; rr_last updates on grant.
//   - Grant cycle: assert AWREADY+WREADY together (write) or ARREADY (read) for exactly 1 cycle, combinationally in IDLE.
//   - Grant cycle: capture addr/data/strb into PADDR/PWDATA/PSTRB; go to SETUP.
//  SETUP: PSEL=1, PENABLE=0, PWRITE per grant, for exactly 1 cycle -> ACCESS.
//  ACCESS
//   - PSEL=1, PENABLE=1; PADDR/PWDATA/PSTRB/PWRITE are held stable.
//   - PREADY=1: capture resp = PSLVERR ? 2'b10 : 2'b00 (and RDATA=PRDATA on a read); go to RESP.
//   - Timeout counter clears on SETUP entry and increments each ACCESS cycle with PREADY=0.
//   - count==TIMEOUT_CYCLES-1 with PREADY=0 (TIMEOUT_CYCLES>0): resp=2'b10, RDATA=0, go to RESP.
//  RESP
//   - PSEL=0, PENABLE=0; BVALID (write) or RVALID (read) asserted with BRESP/RRESP/RDATA held.
//   - Leave to IDLE on the cycle BREADY/RREADY=1; VALID drops the next cycle.
//   - error pulses for 1 cycle on RESP entry when resp=2'b10.
//  Latency: unstalled, grant at cycle 0 -> SETUP 1 -> ACCESS 2 -> VALID at cycle 3.
//   Minimum 4 cycles per transfer; one transfer outstanding at a time.
//  Requests arriving while not IDLE are held off (READY=0); the AXI source must keep VALID.
//  AWVALID without WVALID (or the reverse) is never granted and does not block a pending read.
//  Reset asserted mid-transfer: all state returns to reset values on the next edge; the APB transfer is abandoned.
//  PREADY/PSLVERR/PRDATA are ignored outside ACCESS.
// STRUCTURE
//  Package apb_pkg: typedef enum {IDLE,SETUP,ACCESS,RESP} apb_seq_state_t;
//   constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10; typedef enum {GNT_READ,GNT_WRITE} apb_gnt_t.
//  Sub-module apb_rr_arbiter2: 2-way round-robin (req_rd, req_wr, advance -> gnt, rr_last reg).
//   The rest (FSM, capture regs, timeout counter) stays in this module.
// TESTING
//  1 Write, no wait: AWADDR=0x10, WDATA=0xDEADBEEF, WSTRB=4'hF, PREADY=1
//    -> PSEL at cycle 1, PENABLE at cycle 2, PWDATA=0xDEADBEEF, BVALID at cycle 3, BRESP=00.
//  2 Read with waits: ARADDR=0x24, PREADY low 3 ACCESS cycles then high with PRDATA=0x12345678
//    -> RDATA=0x12345678, RRESP=00, PADDR stable throughout ACCESS.
//  3 Contention: AR and AW+W valid together, both held for 3 transfers -> grant order W,R,W.
//    A lone read after reset is granted immediately.
//  4 Slave error: write with PSLVERR=1 at PREADY -> BRESP=10, error pulses exactly 1 cycle.
//  5 Timeout: read with PREADY stuck 0, TIMEOUT_CYCLES=16 -> RVALID after 16 ACCESS cycles,
//    RRESP=10, RDATA=0, PSEL drops; a repeat run with TIMEOUT_CYCLES=0 waits indefinitely.
//  6 Backpressure/reset: BREADY low 5 cycles -> BVALID/BRESP held and no new grant despite ARVALID;
//    PRESET asserted in ACCESS -> next cycle PSEL=0 and all outputs at reset values.

Source files
------------

// File: rtl/apb_axi_sequencer_pkg.sv
// apb_pkg: shared types and response codes for the AXI4-Lite to APB sequencer.
package apb_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_seq_state_t;
   typedef enum logic {GNT_READ, GNT_WRITE} apb_gnt_t;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/apb_axi_sequencer_rr_arbiter.sv
// apb_rr_arbiter2: two-way round-robin between read and write requests.
module apb_rr_arbiter2
   import apb_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     req_rd,
   input  logic     req_wr,
   input  logic     advance,
   output apb_gnt_t gnt
);
   apb_gnt_t rr_last;
   // On a tie the type that did not win last time goes first.
   assign gnt = (req_rd && req_wr) ? ((rr_last == GNT_READ) ? GNT_WRITE : GNT_READ)
                                   : (req_wr ? GNT_WRITE : GNT_READ);
   always_ff @(posedge clk)
      if (rst)          rr_last <= GNT_READ;
      else if (advance) rr_last <= gnt;
endmodule

// File: rtl/apb_axi_sequencer.sv
// apb_axi_sequencer: AXI4-Lite slave to single APB master, one transfer in flight,
// with round-robin read/write arbitration, PREADY timeout and response generation.
module apb_axi_sequencer
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic [ADDR_WIDTH-1:0]   AWADDR,
   input  logic                    AWVALID,
   output logic                    AWREADY,
   input  logic [DATA_WIDTH-1:0]   WDATA,
   input  logic [DATA_WIDTH/8-1:0] WSTRB,
   input  logic                    WVALID,
   output logic                    WREADY,
   output logic [1:0]              BRESP,
   output logic                    BVALID,
   input  logic                    BREADY,
   input  logic [ADDR_WIDTH-1:0]   ARADDR,
   input  logic                    ARVALID,
   output logic                    ARREADY,
   output logic [DATA_WIDTH-1:0]   RDATA,
   output logic [1:0]              RRESP,
   output logic                    RVALID,
   input  logic                    RREADY,
   output logic                    PSEL,
   output logic                    PENABLE,
   output logic                    PWRITE,
   output logic [ADDR_WIDTH-1:0]   PADDR,
   output logic [DATA_WIDTH-1:0]   PWDATA,
   output logic [DATA_WIDTH/8-1:0] PSTRB,
   input  logic [DATA_WIDTH-1:0]   PRDATA,
   input  logic                    PREADY,
   input  logic                    PSLVERR,
   output logic                    error
);
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   apb_seq_state_t state, state_nx;
   apb_gnt_t gnt;
   logic wr_q, req_rd, req_wr, grant, gnt_wr, timeout, done;
   logic [1:0] resp;
   logic [CW-1:0] cnt;
   assign req_wr  = AWVALID && WVALID;
   assign req_rd  = ARVALID;
   assign grant   = (state == IDLE) && (req_rd || req_wr);
   assign gnt_wr  = (gnt == GNT_WRITE);
   assign timeout = (TIMEOUT_CYCLES > 0) && (cnt == CW'(TIMEOUT_CYCLES - 1)) && !PREADY;
   assign done    = (state == ACCESS) && (PREADY || timeout);
   assign AWREADY = grant && gnt_wr;
   assign WREADY  = AWREADY;
   assign ARREADY = grant && !gnt_wr;
   assign PSEL    = (state == SETUP) || (state == ACCESS);
   assign PENABLE = (state == ACCESS);
   assign PWRITE  = PSEL && wr_q;
   assign BVALID  = (state == RESP) && wr_q;
   assign RVALID  = (state == RESP) && !wr_q;
   assign BRESP   = resp;
   assign RRESP   = resp;
   apb_rr_arbiter2 u_arb (
      .clk(PCLK), .rst(PRESET), .req_rd(req_rd), .req_wr(req_wr), .advance(grant), .gnt(gnt)
   );
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = grant ? SETUP : IDLE;
         SETUP:   state_nx = ACCESS;
         ACCESS:  state_nx = done ? RESP : ACCESS;
         RESP:    state_nx = (wr_q ? BREADY : RREADY) ? IDLE : RESP;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state  <= IDLE;
         wr_q   <= 1'b0;
         PADDR  <= '0;
         PWDATA <= '0;
         PSTRB  <= '0;
         RDATA  <= '0;
         resp   <= RESP_OKAY;
         cnt    <= '0;
         error  <= 1'b0;
      end else begin
         state <= state_nx;
         error <= done && (!PREADY || PSLVERR);
         if (grant) begin
            wr_q   <= gnt_wr;
            PADDR  <= gnt_wr ? AWADDR : ARADDR;
            PWDATA <= gnt_wr ? WDATA : '0;
            PSTRB  <= gnt_wr ? WSTRB : '0;
            cnt    <= '0;
         end
         if ((state == ACCESS) && !PREADY) cnt <= cnt + 1'b1;
         // A timeout is reported as SLVERR with the read data forced to zero.
         if (done) begin
            resp <= (!PREADY || PSLVERR) ? RESP_SLVERR : RESP_OKAY;
            if (!wr_q) RDATA <= PREADY ? PRDATA : '0;
         end
      end
   end
endmodule

// File: tb/tb_apb_axi_sequencer.sv
// tb_apb_axi_sequencer: scenario and randomized checks of apb_axi_sequencer against a
// transaction-level model; a second instance has the timeout disabled.
module tb_apb_axi_sequencer;
   localparam int TO = 16;
   typedef struct {
      int gnt_c, setup_c, acc_c, valid_c, hs_c, n_acc, n_err, bad_gnt;
      bit stable, hold_ok, dropped, psel_resp, pwrite;
      logic [31:0] paddr, pwdata, rdata;
      logic [3:0] pstrb;
      logic [1:0] resp;
   } obs_t;
   logic PCLK = 0, PRESET = 1;
   logic [31:0] AWADDR = 0, WDATA = 0, ARADDR = 0, PRDATA = 0;
   logic [3:0] WSTRB = 0;
   logic AWVALID = 0, WVALID = 0, BREADY = 0, ARVALID = 0, RREADY = 0, PREADY = 0, PSLVERR = 0;
   logic pready_nt = 1;
   logic AWREADY, WREADY, BVALID, ARREADY, RVALID, PSEL, PENABLE, PWRITE, error;
   logic [1:0] BRESP, RRESP;
   logic [31:0] RDATA, PADDR, PWDATA;
   logic [3:0] PSTRB;
   logic nt_awready, nt_wready, nt_bvalid, nt_arready, nt_rvalid, nt_psel, nt_penable, nt_pwrite, nt_error;
   logic [1:0] nt_bresp, nt_rresp;
   logic [31:0] nt_rdata, nt_paddr, nt_pwdata;
   logic [3:0] nt_pstrb;
   int n_chk = 0, n_fail = 0;
   always #5 PCLK = ~PCLK;
   apb_axi_sequencer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY), .BRESP(BRESP),
      .BVALID(BVALID), .BREADY(BREADY), .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY), .PSEL(PSEL),
      .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .error(error)
   );
   apb_axi_sequencer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(0)) dut_nt (
      .PCLK(PCLK), .PRESET(PRESET), .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(nt_awready),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(nt_wready), .BRESP(nt_bresp),
      .BVALID(nt_bvalid), .BREADY(BREADY), .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(nt_arready),
      .RDATA(nt_rdata), .RRESP(nt_rresp), .RVALID(nt_rvalid), .RREADY(RREADY), .PSEL(nt_psel),
      .PENABLE(nt_penable), .PWRITE(nt_pwrite), .PADDR(nt_paddr), .PWDATA(nt_pwdata), .PSTRB(nt_pstrb),
      .PRDATA(PRDATA), .PREADY(pready_nt), .PSLVERR(PSLVERR), .error(nt_error)
   );

   task automatic do_reset();
      @(negedge PCLK);
      PRESET = 1; AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 0; RREADY = 0; PREADY = 0;
      repeat (2) @(negedge PCLK);
      PRESET = 0;
   endtask

   // Plays AXI master and APB slave for one transfer and records what the DUT did.
   task automatic run_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int waits, input bit slv,
                           input logic [31:0] prd, input int bdly, input bit noise, output obs_t o);
      bit hs = 0;
      o.gnt_c = -1; o.setup_c = -1; o.acc_c = -1; o.valid_c = -1; o.hs_c = -1;
      o.n_acc = 0; o.n_err = 0; o.bad_gnt = 0; o.stable = 1; o.hold_ok = 1; o.dropped = 0;
      o.psel_resp = 0; o.pwrite = 0; o.paddr = 'x; o.pwdata = 'x; o.rdata = 'x; o.pstrb = 'x; o.resp = 'x;
      @(negedge PCLK);
      PRDATA = prd; PSLVERR = slv; BREADY = 0; RREADY = 0;
      if (wr) begin
         AWADDR = addr; WDATA = data; WSTRB = strb; AWVALID = 1; WVALID = 1;
      end else begin
         ARADDR = addr; ARVALID = 1; AWVALID = noise; AWADDR = $urandom;
      end
      for (int c = 0; c < 200; c++) begin
         #1;
         if (error) o.n_err++;
         if (hs) begin
            o.dropped = !(BVALID || RVALID);
            break;
         end
         if (wr ? (AWREADY && WREADY) : ARREADY) begin
            if (o.gnt_c < 0) o.gnt_c = c; else o.bad_gnt++;
         end
         if ((wr ? ARREADY : (AWREADY || WREADY)) || AWREADY != WREADY) o.bad_gnt++;
         if (PSEL && !PENABLE && o.setup_c < 0) o.setup_c = c;
         PREADY = 0;
         if (PSEL && PENABLE) begin
            if (o.n_acc == 0) begin
               o.acc_c = c; o.paddr = PADDR; o.pwdata = PWDATA; o.pstrb = PSTRB; o.pwrite = PWRITE;
            end else if ({PADDR, PWDATA, PSTRB, PWRITE} !== {o.paddr, o.pwdata, o.pstrb, o.pwrite}) o.stable = 0;
            PREADY = (o.n_acc == waits);
            o.n_acc++;
         end
         if (BVALID || RVALID) begin
            if (o.valid_c < 0) begin
               o.valid_c = c; o.resp = wr ? BRESP : RRESP; o.rdata = RDATA;
            end else if ((wr ? BRESP : RRESP) !== o.resp || RDATA !== o.rdata) o.hold_ok = 0;
            if (PSEL || PENABLE) o.psel_resp = 1;
            if (BVALID == !wr) o.hold_ok = 0;
            ARVALID = noise && wr;
            if (c - o.valid_c >= bdly) begin
               BREADY = wr; RREADY = !wr; ARVALID = 0; hs = 1; o.hs_c = c;
            end
         end
         @(negedge PCLK);
         if (c == o.gnt_c) begin
            AWVALID = !wr && noise; WVALID = 0; ARVALID = 0;
         end
      end
      AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 0; RREADY = 0; PREADY = 0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_chk++; if ({PSEL, PENABLE, PWRITE, BVALID, RVALID, AWREADY, WREADY, ARREADY, error} !== 9'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 0", {PSEL, PENABLE, PWRITE, BVALID, RVALID, AWREADY, WREADY, ARREADY, error}); end
      n_chk++; if ({PADDR, PWDATA, PSTRB, RDATA} !== 100'b0) begin n_fail++; $display("FAIL reset_data: got %h %h %h %h want 0", PADDR, PWDATA, PSTRB, RDATA); end
      n_chk++; if ({BRESP, RRESP} !== 4'b0) begin n_fail++; $display("FAIL reset_resp: got %b want 0000", {BRESP, RRESP}); end
   endtask

   task automatic test_write_nowait();
      obs_t o;
      run_xfer(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0, 0, 0, o);
      n_chk++; if (o.setup_c !== 1) begin n_fail++; $display("FAIL wr_psel_cycle: got %0d want 1", o.setup_c); end
      n_chk++; if (o.acc_c !== 2) begin n_fail++; $display("FAIL wr_penable_cycle: got %0d want 2", o.acc_c); end
      n_chk++; if (o.pwdata !== 32'hDEADBEEF || o.paddr !== 32'h10 || o.pwrite !== 1) begin n_fail++; $display("FAIL wr_apb: got %h %h %b want deadbeef 10 1", o.pwdata, o.paddr, o.pwrite); end
      n_chk++; if (o.valid_c !== 3) begin n_fail++; $display("FAIL wr_bvalid_cycle: got %0d want 3", o.valid_c); end
      n_chk++; if (o.resp !== 2'b00) begin n_fail++; $display("FAIL wr_bresp: got %b want 00", o.resp); end
   endtask

   task automatic test_read_waits();
      obs_t o;
      run_xfer(0, 32'h24, 32'h0, 4'h0, 3, 0, 32'h12345678, 0, 0, o);
      n_chk++; if (o.rdata !== 32'h12345678) begin n_fail++; $display("FAIL rd_rdata: got %h want 12345678", o.rdata); end
      n_chk++; if (o.resp !== 2'b00) begin n_fail++; $display("FAIL rd_rresp: got %b want 00", o.resp); end
      n_chk++; if (o.stable !== 1 || o.paddr !== 32'h24) begin n_fail++; $display("FAIL rd_paddr_stable: got %b %h want 1 24", o.stable, o.paddr); end
      n_chk++; if (o.pstrb !== 4'h0 || o.pwrite !== 0) begin n_fail++; $display("FAIL rd_pstrb_pwrite: got %h %b want 0 0", o.pstrb, o.pwrite); end
      n_chk++; if (o.valid_c !== 6) begin n_fail++; $display("FAIL rd_rvalid_cycle: got %0d want 6", o.valid_c); end
   endtask

   task automatic test_contention();
      obs_t o;
      bit last_wr = 0;
      bit exp_wr;
      int n = 0;
      do_reset();
      @(negedge PCLK);
      AWADDR = $urandom; WDATA = $urandom; WSTRB = 4'hF; ARADDR = $urandom;
      AWVALID = 1; WVALID = 1; ARVALID = 1; PREADY = 1; PSLVERR = 0; BREADY = 1; RREADY = 1;
      for (int c = 0; c < 40 && n < 3; c++) begin
         #1;
         if (AWREADY || ARREADY) begin
            exp_wr = !last_wr;
            n_chk++; if (AWREADY !== exp_wr || ARREADY !== !exp_wr) begin n_fail++; $display("FAIL contention_grant%0d: got aw=%b ar=%b want write=%b", n, AWREADY, ARREADY, exp_wr); end
            last_wr = exp_wr;
            n++;
         end
         @(negedge PCLK);
      end
      n_chk++; if (n != 3) begin n_fail++; $display("FAIL contention_count: got %0d grants want 3", n); end
      AWVALID = 0; WVALID = 0; ARVALID = 0;
      repeat (6) @(negedge PCLK);
      PREADY = 0; BREADY = 0; RREADY = 0;
      do_reset();
      run_xfer(0, 32'h40, 32'h0, 4'h0, 0, 0, 32'hA5A50001, 0, 0, o);
      n_chk++; if (o.gnt_c !== 0) begin n_fail++; $display("FAIL lone_read_grant: got cycle %0d want 0", o.gnt_c); end
      n_chk++; if (o.rdata !== 32'hA5A50001) begin n_fail++; $display("FAIL lone_read_rdata: got %h want a5a50001", o.rdata); end
   endtask

   task automatic test_slverr();
      obs_t o;
      run_xfer(1, 32'h0000_0100, 32'hCAFE0000, 4'h5, 1, 1, 32'h0, 0, 0, o);
      n_chk++; if (o.resp !== 2'b10) begin n_fail++; $display("FAIL slverr_bresp: got %b want 10", o.resp); end
      n_chk++; if (o.n_err !== 1) begin n_fail++; $display("FAIL slverr_error_pulse: got %0d cycles want 1", o.n_err); end
      n_chk++; if (o.valid_c !== 4) begin n_fail++; $display("FAIL slverr_bvalid_cycle: got %0d want 4", o.valid_c); end
   endtask

   task automatic test_timeout();
      obs_t o;
      run_xfer(0, 32'h200, 32'h0, 4'h0, 15, 0, 32'h5A5A5A5A, 0, 0, o);
      n_chk++; if (o.resp !== 2'b00 || o.rdata !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL ready_at_last_cycle: got %b %h want 00 5a5a5a5a", o.resp, o.rdata); end
      pready_nt = 0;
      run_xfer(0, 32'h204, 32'h0, 4'h0, -1, 0, 32'hFFFFFFFF, 0, 0, o);
      n_chk++; if (o.valid_c !== 2 + TO) begin n_fail++; $display("FAIL timeout_rvalid_cycle: got %0d want %0d", o.valid_c, 2 + TO); end
      n_chk++; if (o.n_acc !== TO) begin n_fail++; $display("FAIL timeout_access_cycles: got %0d want %0d", o.n_acc, TO); end
      n_chk++; if (o.resp !== 2'b10 || o.rdata !== 32'h0) begin n_fail++; $display("FAIL timeout_resp: got %b %h want 10 0", o.resp, o.rdata); end
      n_chk++; if (o.psel_resp !== 0 || o.n_err !== 1) begin n_fail++; $display("FAIL timeout_psel_err: got psel=%b err=%0d want 0 1", o.psel_resp, o.n_err); end
      repeat (20) @(negedge PCLK);
      #1;
      n_chk++; if ({nt_psel, nt_penable, nt_rvalid} !== 3'b110) begin n_fail++; $display("FAIL no_timeout_waits: got %b want 110", {nt_psel, nt_penable, nt_rvalid}); end
      do_reset();
      pready_nt = 1;
   endtask

   task automatic test_backpressure();
      obs_t o;
      run_xfer(1, 32'h80, 32'h11223344, 4'h3, 0, 0, 32'h0, 5, 1, o);
      n_chk++; if (o.hs_c - o.valid_c !== 5) begin n_fail++; $display("FAIL bp_held_cycles: got %0d want 5", o.hs_c - o.valid_c); end
      n_chk++; if (o.hold_ok !== 1 || o.resp !== 2'b00) begin n_fail++; $display("FAIL bp_bresp_hold: got %b %b want 1 00", o.hold_ok, o.resp); end
      n_chk++; if (o.bad_gnt !== 0) begin n_fail++; $display("FAIL bp_no_grant: got %0d extra grants want 0", o.bad_gnt); end
      n_chk++; if (o.dropped !== 1) begin n_fail++; $display("FAIL bp_valid_drop: got %b want 1", o.dropped); end
   endtask

   task automatic test_reset_midxfer();
      @(negedge PCLK);
      AWADDR = 32'h300; WDATA = 32'h77; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; PREADY = 0;
      @(negedge PCLK);
      AWVALID = 0; WVALID = 0;
      @(negedge PCLK);
      #1;
      n_chk++; if ({PSEL, PENABLE, PWRITE} !== 3'b111) begin n_fail++; $display("FAIL midrst_in_access: got %b want 111", {PSEL, PENABLE, PWRITE}); end
      PRESET = 1;
      @(negedge PCLK);
      #1;
      PRESET = 0;
      n_chk++; if ({PSEL, PENABLE, PWRITE, BVALID, RVALID, AWREADY, WREADY, ARREADY, error} !== 9'b0) begin n_fail++; $display("FAIL midrst_ctrl: got %b want 0", {PSEL, PENABLE, PWRITE, BVALID, RVALID, AWREADY, WREADY, ARREADY, error}); end
      n_chk++; if ({PADDR, PWDATA, PSTRB, BRESP, RRESP} !== 72'b0) begin n_fail++; $display("FAIL midrst_data: got %h %h %h %b %b want 0", PADDR, PWDATA, PSTRB, BRESP, RRESP); end
      repeat (3) @(negedge PCLK);
      #1;
      n_chk++; if (PSEL !== 0) begin n_fail++; $display("FAIL midrst_abandoned: got psel=%b want 0", PSEL); end
   endtask

   task automatic test_random();
      obs_t o;
      bit wr, slv, noise, to;
      int waits, bdly, ev, en;
      logic [31:0] addr, data, prd;
      logic [3:0] strb;
      logic [1:0] er;
      for (int i = 0; i < 30; i++) begin
         wr = $urandom_range(0, 1); slv = ($urandom_range(0, 3) == 0); noise = $urandom_range(0, 1);
         waits = ($urandom_range(0, 4) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 6);
         bdly = $urandom_range(0, 3); addr = $urandom; data = $urandom; prd = $urandom; strb = 4'($urandom);
         run_xfer(wr, addr, data, strb, waits, slv, prd, bdly, noise, o);
         to = (waits >= TO);
         ev = to ? 2 + TO : 3 + waits;
         en = to ? TO : waits + 1;
         er = (to || slv) ? 2'b10 : 2'b00;
         n_chk++; if (o.gnt_c !== 0 || o.setup_c !== 1 || o.acc_c !== 2) begin n_fail++; $display("FAIL rand%0d_phases: got %0d %0d %0d want 0 1 2", i, o.gnt_c, o.setup_c, o.acc_c); end
         n_chk++; if (o.valid_c !== ev || o.n_acc !== en) begin n_fail++; $display("FAIL rand%0d_latency: got %0d/%0d want %0d/%0d", i, o.valid_c, o.n_acc, ev, en); end
         n_chk++; if (o.resp !== er) begin n_fail++; $display("FAIL rand%0d_resp: got %b want %b", i, o.resp, er); end
         n_chk++; if (o.n_err !== ((er == 2'b10) ? 1 : 0)) begin n_fail++; $display("FAIL rand%0d_error: got %0d want %0d", i, o.n_err, (er == 2'b10) ? 1 : 0); end
         n_chk++; if (o.paddr !== addr || o.pwrite !== wr || o.stable !== 1) begin n_fail++; $display("FAIL rand%0d_apb: got %h %b %b want %h %b 1", i, o.paddr, o.pwrite, o.stable, addr, wr); end
         n_chk++; if (o.pstrb !== (wr ? strb : 4'h0)) begin n_fail++; $display("FAIL rand%0d_pstrb: got %h want %h", i, o.pstrb, wr ? strb : 4'h0); end
         if (wr) begin
            n_chk++; if (o.pwdata !== data) begin n_fail++; $display("FAIL rand%0d_pwdata: got %h want %h", i, o.pwdata, data); end
         end else begin
            n_chk++; if (o.rdata !== (to ? 32'h0 : prd)) begin n_fail++; $display("FAIL rand%0d_rdata: got %h want %h", i, o.rdata, to ? 32'h0 : prd); end
         end
         n_chk++; if (o.bad_gnt !== 0 || o.hold_ok !== 1 || o.dropped !== 1 || o.psel_resp !== 0) begin n_fail++; $display("FAIL rand%0d_handshake: got bad=%0d hold=%b drop=%b psel=%b want 0 1 1 0", i, o.bad_gnt, o.hold_ok, o.dropped, o.psel_resp); end
         n_chk++; if (o.hs_c - o.valid_c !== bdly) begin n_fail++; $display("FAIL rand%0d_held: got %0d want %0d", i, o.hs_c - o.valid_c, bdly); end
      end
   endtask

   initial begin
      test_reset();
      test_write_nowait();
      test_read_waits();
      test_contention();
      test_slverr();
      test_timeout();
      test_backpressure();
      test_reset_midxfer();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
